sat_ctr_pht: RTL and testbench
==============================

# sat_ctr_pht

Parametrised pattern history table for the branch predictor. It holds 2^IDX_W saturating counters of CTR_W bits, with one prediction read port and one training update port per cycle. It also keeps a saturating mispredict counter. It sits between the fetch-side index generator (prediction) and the resolve stage (update), and generalises the single 2-bit taken/not-taken state machine to a full table of configurable width and depth.

## Interface
- CTR_W, 2: counter width in bits, ≥1; taken when MSB = 1.
- IDX_W, 6: index width; table depth = 2^IDX_W.
- INIT, 1: counter value loaded at reset, 0..2^CTR_W−1; default 1 is weakly not-taken.
- MIS_W, 16: mispredict counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- pred_valid  in  1  prediction lookup request.
- pred_idx  in  IDX_W  lookup index.
- pred_out_valid  out  1  registered pred_valid.
- pred_taken  out  1  MSB of the looked-up counter.
- pred_ctr  out  CTR_W  full looked-up counter value.
- upd_valid  in  1  training update request.
- upd_idx  in  IDX_W  index to train.
- upd_taken  in  1  resolved branch direction.
- upd_changed  out  1  registered flag: last update modified the entry (not saturated).
- mis_cnt  out  MIS_W  count of updates whose pre-update MSB ≠ upd_taken.

## Operation
- Counter rule, applied on update to the entry at upd_idx:
  - If upd_taken: next = min(cur+1, 2^CTR_W−1).
  - Else: next = max(cur−1, 0).
  - All arithmetic is CTR_W-bit unsigned; wrap-around never occurs.
- For CTR_W=2 the values are WELL_NTAKEN=0, NTAKEN=1, TAKEN=2, WELL_TAKEN=3.
- The update writes the table at the clock edge in the cycle upd_valid=1.
- upd_changed is registered as (next ≠ cur) when upd_valid=1, else 0.
- Mispredict: when upd_valid=1 and cur[CTR_W−1] ≠ upd_taken, mis_cnt increments. It saturates at 2^MIS_W−1 and does not wrap.
- Prediction: when pred_valid=1, the entry at pred_idx is captured into pred_ctr/pred_taken. When pred_valid=0, pred_ctr/pred_taken hold their previous values.
- Same-cycle collision (pred_valid, upd_valid, pred_idx == upd_idx): the prediction returns the post-update value (write-first bypass).
- Updates to different indices in consecutive cycles are independent. Back-to-back updates to the same index accumulate; each sees the prior cycle's write.
- Reset:
  - All table entries are set to INIT in one cycle.
  - pred_out_valid=0, pred_taken=0, pred_ctr=0, upd_changed=0, mis_cnt=0.
  - Requests presented while reset=1 are dropped, with no table or counter effect.
- Reset mid-stream: any update in the reset cycle is lost. The cycle after reset deasserts behaves as a fresh table.

## Timing
- Prediction latency is 1 cycle: request in cycle N, pred_out_valid/pred_ctr valid in cycle N+1.
- Update takes effect at the edge ending cycle N. A lookup in cycle N+1 sees it, and so does a same-index lookup in cycle N via the bypass.
- upd_changed and mis_cnt reflect the update of cycle N in cycle N+1.
- Both ports accept a request every cycle. There is no backpressure and no busy state.
- All outputs are registered and there is no combinational input→output path.

## Structure
- Shared header (br_pre_header) holds:
  - defaults for CTR_W, IDX_W, INIT, MIS_W;
  - the named 2-bit state constants WELL_NTAKEN/NTAKEN/TAKEN/WELL_TAKEN;
  - a TAKEN_BIT = CTR_W−1 helper.
- One sub-module, sat_ctr_next: combinational (cur, taken) → (next, changed), parametrised by CTR_W. It is instantiated once for the update path, and its next output feeds both the table write and the bypass mux.
- The table is a flop array (reset-to-INIT needs single-cycle clear), not inferred RAM.

## Test plan
- Reset, then lookup idx 0 and idx 63 → pred_ctr=1, pred_taken=0 one cycle later; mis_cnt=0.
- Four taken updates to idx 5, then lookup idx 5 → pred_ctr=3, pred_taken=1.
  - upd_changed sequence 1,1,0,0.
  - mis_cnt=1: only the first update mispredicts, since its pre-update MSB was 0.
- Same-cycle pred_idx=upd_idx=9, upd_taken=1, entry=1 → pred_ctr=2, pred_taken=1 next cycle.
- Not-taken update on idx 2 at 0 → entry stays 0, upd_changed=0, mis_cnt unchanged.
- MIS_W=2 with 5 alternating mispredicts on one index → mis_cnt saturates at 3.
- Update to idx 7 with reset=1 in the same cycle → after reset, idx 7 reads INIT and mis_cnt=0.
  - Repeat with CTR_W=3, INIT=3: seven taken updates saturate the entry at 7.

Source files
------------

// File: rtl/sat_ctr_pht_pkg.sv
// Shared branch-predictor definitions: parameter defaults, named 2-bit counter
// states and the taken-bit position helper.
package sat_ctr_pht_pkg;

    localparam int CTR_W_DEF = 2;
    localparam int IDX_W_DEF = 6;
    localparam int INIT_DEF  = 1;
    localparam int MIS_W_DEF = 16;

    localparam logic [1:0] WELL_NTAKEN = 2'd0;
    localparam logic [1:0] NTAKEN      = 2'd1;
    localparam logic [1:0] TAKEN       = 2'd2;
    localparam logic [1:0] WELL_TAKEN  = 2'd3;

    function automatic int taken_bit(input int ctr_w);
        return ctr_w - 1;
    endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Next-state logic for one saturating counter: step toward the resolved
// direction, clamping at both ends, and flag whether the value moved.
module sat_ctr_next
    import sat_ctr_pht_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] next,
    output logic             changed
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c,
                                                  input logic             t);
        if (t)
            return (c == CTR_MAX) ? c : c + CTR_W'(1);
        else
            return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    always_comb begin
        next    = sat_step(cur, taken);
        changed = (next != cur);
    end

endmodule

// File: rtl/sat_ctr_pht.sv
// Pattern history table of saturating counters with one lookup port, one
// training port, write-first bypass on collision and a saturating mispredict count.
module sat_ctr_pht
    import sat_ctr_pht_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int INIT  = INIT_DEF,
    parameter int MIS_W = MIS_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_out_valid,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_changed,
    output logic [MIS_W-1:0] mis_cnt
);

    localparam int DEPTH     = 1 << IDX_W;
    localparam int TAKEN_MSB = taken_bit(CTR_W);

    function automatic logic [MIS_W-1:0] sat_inc(input logic [MIS_W-1:0] v);
        return (v == '1) ? v : v + MIS_W'(1);
    endfunction

    // Flop array so that reset can restore every entry in a single cycle.
    logic [CTR_W-1:0] tbl [DEPTH];

    logic [CTR_W-1:0] upd_cur_p0;
    logic [CTR_W-1:0] upd_next_p0;
    logic             upd_chg_p0;
    logic             upd_mis_p0;
    logic [CTR_W-1:0] pred_rd_p0;

    logic             vld_p1;
    logic [CTR_W-1:0] pred_ctr_p1;
    logic             upd_chg_p1;
    logic [MIS_W-1:0] mis_cnt_p1;

    // Stage p0: table read, counter step, collision bypass.
    assign upd_cur_p0 = tbl[upd_idx];

    sat_ctr_next #(.CTR_W(CTR_W)) u_next (
        .cur     (upd_cur_p0),
        .taken   (upd_taken),
        .next    (upd_next_p0),
        .changed (upd_chg_p0)
    );

    assign upd_mis_p0 = (upd_cur_p0[TAKEN_MSB] != upd_taken);
    assign pred_rd_p0 = (upd_valid && (upd_idx == pred_idx)) ? upd_next_p0 : tbl[pred_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= CTR_W'(INIT);
        end else if (upd_valid) begin
            tbl[upd_idx] <= upd_next_p0;
        end
    end

    // Stage p1: registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            pred_ctr_p1 <= '0;
            upd_chg_p1  <= 1'b0;
            mis_cnt_p1  <= '0;
        end else begin
            vld_p1     <= pred_valid;
            upd_chg_p1 <= upd_valid & upd_chg_p0;
            if (pred_valid)
                pred_ctr_p1 <= pred_rd_p0;
            if (upd_valid && upd_mis_p0)
                mis_cnt_p1 <= sat_inc(mis_cnt_p1);
        end
    end

    assign pred_out_valid = vld_p1;
    assign pred_ctr       = pred_ctr_p1;
    assign pred_taken     = pred_ctr_p1[TAKEN_MSB];
    assign upd_changed    = upd_chg_p1;
    assign mis_cnt        = mis_cnt_p1;

endmodule

// File: tb/tb_sat_ctr_pht.sv
// Scoreboard bench for sat_ctr_pht: three configurations (default, MIS_W=2,
// CTR_W=3/INIT=3) driven with identical stimulus and compared to a reference model.
module tb_sat_ctr_pht;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pred_valid = 1'b0;
    logic [5:0] pred_idx = '0;
    logic       upd_valid = 1'b0;
    logic [5:0] upd_idx = '0;
    logic       upd_taken = 1'b0;

    logic        p0_ov, p0_tk, p0_chg;
    logic [1:0]  p0_ctr;
    logic [15:0] p0_mis;
    logic        p1_ov, p1_tk, p1_chg;
    logic [1:0]  p1_ctr;
    logic [1:0]  p1_mis;
    logic        p2_ov, p2_tk, p2_chg;
    logic [2:0]  p2_ctr;
    logic [15:0] p2_mis;

    always #5 clk = ~clk;

    sat_ctr_pht u_dut0 (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_idx(pred_idx),
        .pred_out_valid(p0_ov), .pred_taken(p0_tk), .pred_ctr(p0_ctr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_changed(p0_chg), .mis_cnt(p0_mis)
    );

    sat_ctr_pht #(.MIS_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_idx(pred_idx),
        .pred_out_valid(p1_ov), .pred_taken(p1_tk), .pred_ctr(p1_ctr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_changed(p1_chg), .mis_cnt(p1_mis)
    );

    sat_ctr_pht #(.CTR_W(3), .INIT(3)) u_dut2 (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_idx(pred_idx),
        .pred_out_valid(p2_ov), .pred_taken(p2_tk), .pred_ctr(p2_ctr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_changed(p2_chg), .mis_cnt(p2_mis)
    );

    typedef struct packed {
        logic             pov;
        logic [2:0][2:0]  pred;
        logic [2:0]       chg;
        logic [2:0][15:0] mis;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int cw   [3] = '{2, 2, 3};
    int ini  [3] = '{1, 1, 3};
    int mmax [3] = '{65535, 3, 65535};

    int mt     [3][64];
    int m_pred [3];
    int m_chg  [3];
    int m_mis  [3];
    int m_pov;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rs, input logic pv, input logic [5:0] pi,
                              input logic uv, input logic [5:0] ui, input logic ut);
        exp_t e;
        int cur, nxt, maxv;
        if (rs) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 64; i++) mt[c][i] = ini[c];
                m_pred[c] = 0;
                m_chg[c]  = 0;
                m_mis[c]  = 0;
            end
            m_pov = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                maxv = (1 << cw[c]) - 1;
                cur  = mt[c][ui];
                if (ut) nxt = (cur < maxv) ? cur + 1 : cur;
                else    nxt = (cur > 0) ? cur - 1 : 0;
                if (pv) m_pred[c] = (uv && pi == ui) ? nxt : mt[c][pi];
                m_chg[c] = (uv && nxt != cur) ? 1 : 0;
                if (uv && (((cur >> (cw[c] - 1)) & 1) != int'(ut)) && m_mis[c] < mmax[c])
                    m_mis[c]++;
                if (uv) mt[c][ui] = nxt;
            end
            m_pov = int'(pv);
        end
        e.pov = m_pov[0];
        for (int c = 0; c < 3; c++) begin
            e.pred[c] = m_pred[c][2:0];
            e.chg[c]  = m_chg[c][0];
            e.mis[c]  = m_mis[c][15:0];
        end
        exp_q.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        int g_ov[3], g_tk[3], g_ctr[3], g_chg[3], g_mis[3];
        if (exp_q.size() == 0) begin
            check({tag, "/queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        g_ov  = '{int'(p0_ov), int'(p1_ov), int'(p2_ov)};
        g_tk  = '{int'(p0_tk), int'(p1_tk), int'(p2_tk)};
        g_ctr = '{int'(p0_ctr), int'(p1_ctr), int'(p2_ctr)};
        g_chg = '{int'(p0_chg), int'(p1_chg), int'(p2_chg)};
        g_mis = '{int'(p0_mis), int'(p1_mis), int'(p2_mis)};
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s/c%0d/ov", tag, c),  g_ov[c],  int'(e.pov));
            check($sformatf("%s/c%0d/ctr", tag, c), g_ctr[c], int'(e.pred[c]));
            check($sformatf("%s/c%0d/tk", tag, c),  g_tk[c],  int'(e.pred[c]) >> (cw[c] - 1));
            check($sformatf("%s/c%0d/chg", tag, c), g_chg[c], int'(e.chg[c]));
            check($sformatf("%s/c%0d/mis", tag, c), g_mis[c], int'(e.mis[c]));
        end
    endtask

    task automatic step(input logic rs, input logic pv, input logic [5:0] pi,
                        input logic uv, input logic [5:0] ui, input logic ut,
                        input string tag);
        reset      = rs;
        pred_valid = pv;
        pred_idx   = pi;
        upd_valid  = uv;
        upd_idx    = ui;
        upd_taken  = ut;
        model_step(rs, pv, pi, uv, ui, ut);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a concurrent update to idx 7 that must be dropped
        step(1, 0, 0, 1, 7, 1, "rst_upd");
        step(1, 0, 0, 0, 0, 0, "rst");
        check("rst_mis_const", int'(p0_mis), 0);
        step(0, 1, 0,  0, 0, 0, "lk0");
        check("lk0_const", int'(p0_ctr), 1);
        step(0, 1, 63, 0, 0, 0, "lk63");
        step(0, 1, 7,  0, 0, 0, "lk7");
        check("lk7_const", int'(p0_ctr), 1);

        // Four taken updates to idx 5
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 5, 1, $sformatf("t5_%0d", k));
        step(0, 1, 5, 0, 0, 0, "lk5");
        check("lk5_const", int'(p0_ctr), 3);
        check("lk5_mis_const", int'(p0_mis), 1);

        // Collision bypass on idx 9
        step(0, 1, 9, 1, 9, 1, "col9");
        check("col9_const", int'(p0_ctr), 2);

        // Idle cycle: prediction holds
        step(0, 0, 9, 0, 0, 0, "hold");

        // Not-taken on an entry already at 0
        step(0, 0, 0, 1, 2, 0, "nt2_a");
        step(0, 0, 0, 1, 2, 0, "nt2_b");
        check("nt2_chg_const", int'(p0_chg), 0);
        step(0, 1, 2, 0, 0, 0, "lk2");

        // Alternating mispredicts on idx 10
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 10, (k % 2 == 0), $sformatf("alt_%0d", k));
        check("mis_sat_const", int'(p1_mis), 3);

        // Reset mid-stream with an update in the reset cycle
        step(0, 0, 0, 1, 7, 1, "pre7");
        step(1, 0, 0, 1, 7, 1, "rst7");
        step(0, 1, 7, 0, 0, 0, "post7");
        check("post7_const", int'(p0_ctr), 1);

        // Seven taken updates on idx 20 saturate the 3-bit counter at 7
        for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 20, 1, $sformatf("t20_%0d", k));
        step(0, 1, 20, 0, 0, 0, "lk20");
        check("c3sat_const", int'(p2_ctr), 7);

        // Random traffic over a small index window to provoke collisions
        for (int k = 0; k < 300; k++) begin
            logic       rs, pv, uv, ut;
            logic [5:0] pi, ui;
            rs = ($urandom_range(0, 59) == 0);
            pv = $urandom_range(0, 1);
            uv = $urandom_range(0, 3) != 0;
            ut = $urandom_range(0, 1);
            pi = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            ui = 6'($urandom_range(0, 7));
            step(rs, pv, pi, uv, ui, ut, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
